// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter: inhibit, request-to-send, clocked-out frame, ack check.
// Line drive is through active-high pull-down enables; all outputs are registered.
module ps2_host_tx #(
    parameter int unsigned INHIBIT_CYCLES = 12000,
    parameter int unsigned TIMEOUT_CYCLES = 2000000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    input  logic       kb_clk_in,
    input  logic       kb_data_in,
    output logic       kb_clk_pd,
    output logic       kb_data_pd,
    output logic       busy,
    output logic       done,
    output logic       err_nack,
    output logic       err_timeout
);

    localparam int unsigned CNT_MAX = (INHIBIT_CYCLES > TIMEOUT_CYCLES) ? INHIBIT_CYCLES : TIMEOUT_CYCLES;
    localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);
    localparam logic [CNT_W-1:0] INH_LAST = CNT_W'(INHIBIT_CYCLES - 1);
    localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    // S_FIN is the single done cycle; busy stays high so tx_ready returns the cycle after done
    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_INHIBIT   = 3'd1,
        S_REQ       = 3'd2,
        S_SEND      = 3'd3,
        S_ACK       = 3'd4,
        S_WAIT_IDLE = 3'd5,
        S_FIN       = 3'd6
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [3:0]       bit_idx_q, bit_idx_d;
    logic [7:0]       byte_q, byte_d;
    logic             par_q, par_d;
    logic             nack_q, nack_d;
    logic             tmo_q, tmo_d;
    logic [2:0]       clk_sync_q;
    logic [1:0]       data_sync_q;
    logic             clk_pd_q, clk_pd_d;
    logic             data_pd_q, data_pd_d;
    logic             ready_q, busy_q, done_q, err_nack_q, err_timeout_q;
    logic             fe_s, timeout_s;

    function automatic logic odd_parity(input logic [7:0] b);
        return ~^b;
    endfunction

    // clk_sync_q[1] is the synced clock, clk_sync_q[2] its previous value
    assign fe_s      = clk_sync_q[2] & ~clk_sync_q[1];
    assign timeout_s = (cnt_q == TMO_LAST);

    // Line synchronisers, reset to the idle-high level so no false edge follows reset
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            clk_sync_q  <= 3'b111;
            data_sync_q <= 2'b11;
        end else begin
            clk_sync_q  <= {clk_sync_q[1:0], kb_clk_in};
            data_sync_q <= {data_sync_q[0], kb_data_in};
        end
    end

    // Next-state and next-output logic
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        bit_idx_d = bit_idx_q;
        byte_d    = byte_q;
        par_d     = par_q;
        nack_d    = nack_q;
        tmo_d     = tmo_q;
        data_pd_d = data_pd_q;
        case (state_q)
            S_IDLE: begin
                data_pd_d = 1'b0;
                cnt_d     = '0;
                if (tx_valid) begin
                    byte_d  = tx_data;
                    par_d   = odd_parity(tx_data);
                    nack_d  = 1'b0;
                    tmo_d   = 1'b0;
                    state_d = S_INHIBIT;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_INHIBIT: begin
                data_pd_d = 1'b0;
                if (cnt_q == INH_LAST) begin
                    state_d   = S_REQ;
                    cnt_d     = '0;
                    data_pd_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_REQ, S_SEND, S_ACK, S_WAIT_IDLE: begin
                cnt_d = cnt_q + CNT_W'(1);
                // Timeout wins over any edge seen in the same cycle
                if (timeout_s) begin
                    state_d   = S_FIN;
                    tmo_d     = 1'b1;
                    nack_d    = 1'b0;
                    data_pd_d = 1'b0;
                end else begin
                    case (state_q)
                        S_REQ: begin
                            state_d   = S_SEND;
                            bit_idx_d = 4'd0;
                            data_pd_d = 1'b1;
                        end
                        S_SEND: begin
                            if (fe_s) begin
                                bit_idx_d = bit_idx_q + 4'd1;
                                if (bit_idx_q < 4'd8) begin
                                    data_pd_d = ~byte_q[bit_idx_q[2:0]];
                                end else if (bit_idx_q == 4'd8) begin
                                    data_pd_d = ~par_q;
                                end else begin
                                    data_pd_d = 1'b0;
                                    state_d   = S_ACK;
                                end
                            end else begin
                                bit_idx_d = bit_idx_q;
                            end
                        end
                        S_ACK: begin
                            if (fe_s) begin
                                nack_d  = data_sync_q[1];
                                state_d = S_WAIT_IDLE;
                            end else begin
                                nack_d = nack_q;
                            end
                        end
                        S_WAIT_IDLE: begin
                            if (clk_sync_q[1] && data_sync_q[1]) begin
                                state_d = S_FIN;
                            end else begin
                                state_d = S_WAIT_IDLE;
                            end
                        end
                        default: state_d = S_IDLE;
                    endcase
                end
            end
            S_FIN: begin
                state_d   = S_IDLE;
                cnt_d     = '0;
                nack_d    = 1'b0;
                tmo_d     = 1'b0;
                data_pd_d = 1'b0;
            end
            default: begin
                state_d   = S_IDLE;
                data_pd_d = 1'b0;
            end
        endcase
        clk_pd_d = (state_d == S_INHIBIT) || (state_d == S_REQ);
    end

    // State, datapath and registered outputs; reset releases both lines at once
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= S_IDLE;
            cnt_q         <= '0;
            bit_idx_q     <= 4'd0;
            byte_q        <= 8'd0;
            par_q         <= 1'b0;
            nack_q        <= 1'b0;
            tmo_q         <= 1'b0;
            clk_pd_q      <= 1'b0;
            data_pd_q     <= 1'b0;
            ready_q       <= 1'b1;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            err_nack_q    <= 1'b0;
            err_timeout_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            bit_idx_q     <= bit_idx_d;
            byte_q        <= byte_d;
            par_q         <= par_d;
            nack_q        <= nack_d;
            tmo_q         <= tmo_d;
            clk_pd_q      <= clk_pd_d;
            data_pd_q     <= data_pd_d;
            ready_q       <= (state_d == S_IDLE);
            busy_q        <= (state_d != S_IDLE);
            done_q        <= (state_d == S_FIN);
            err_nack_q    <= (state_d == S_FIN) & nack_d;
            err_timeout_q <= (state_d == S_FIN) & tmo_d;
        end
    end

    assign tx_ready    = ready_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign err_nack    = err_nack_q;
    assign err_timeout = err_timeout_q;
    assign kb_clk_pd   = clk_pd_q;
    assign kb_data_pd  = data_pd_q;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Bench for ps2_host_tx: behavioural transaction model checked every cycle, plus a PS/2 device model.
`timescale 1ns/1ps
module tb_ps2_host_tx;

    localparam int INH  = 20;
    localparam int TMO  = 5000;
    localparam int HALF = 1000;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready, kb_clk_pd, kb_data_pd, busy, done, err_nack, err_timeout;
    logic       dev_clk_low, dev_data_low, dev_abort;
    logic       kb_clk_line, kb_data_line;

    assign kb_clk_line  = ~(kb_clk_pd | dev_clk_low);
    assign kb_data_line = ~(kb_data_pd | dev_data_low);

    ps2_host_tx #(.INHIBIT_CYCLES(INH), .TIMEOUT_CYCLES(TMO)) dut (
        .clk(clk), .rst(rst), .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .kb_clk_in(kb_clk_line), .kb_data_in(kb_data_line),
        .kb_clk_pd(kb_clk_pd), .kb_data_pd(kb_data_pd), .busy(busy), .done(done),
        .err_nack(err_nack), .err_timeout(err_timeout)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Frame as seen on the wire: start 0, data LSB first, odd parity, stop 1
    function automatic logic [10:0] frame_of(input logic [7:0] b);
        return {1'b1, ~^b, b, 1'b0};
    endfunction

    // Transaction model: a request is taken only when idle; n counts cycles since acceptance
    bit m_busy = 1'b0;
    int n = 0;
    int accepts = 0;
    int dones = 0;
    int done_n = 0;
    int clk_hi_cnt = 0;
    int both_hi_cnt = 0;
    bit exp_nack = 1'b0;
    bit exp_to = 1'b0;

    always @(negedge clk) begin
        if (!rst) begin
            m_busy = 1'b0;
            n = 0;
        end else begin
            check("tx_ready", 32'(tx_ready), 32'(!m_busy));
            check("busy", 32'(busy), 32'(m_busy));
            if (!done) check("err_outside_done", 32'({err_nack, err_timeout}), 32'd0);
            if (m_busy && n <= INH) check("inhibit_pd", 32'({kb_clk_pd, kb_data_pd}), 32'b10);
            else if (m_busy && n == INH + 1) check("req_pd", 32'({kb_clk_pd, kb_data_pd}), 32'b11);
            else if (m_busy && n == INH + 2) check("send_start_pd", 32'({kb_clk_pd, kb_data_pd}), 32'b01);
            else if (m_busy) check("clk_released", 32'(kb_clk_pd), 32'd0);
            else check("idle_pd", 32'({kb_clk_pd, kb_data_pd}), 32'd0);
            if (kb_clk_pd) clk_hi_cnt++;
            if (kb_clk_pd && kb_data_pd) both_hi_cnt++;
            if (done) begin
                check("spurious_done", 32'(m_busy), 32'd1);
                check("done_flags", 32'({err_nack, err_timeout}), 32'({exp_nack, exp_to}));
                check("done_pd", 32'({kb_clk_pd, kb_data_pd}), 32'd0);
                if (exp_to) check("timeout_cycle", 32'(n), 32'(INH + 1 + TMO));
                dones++;
                done_n = n;
            end else if (m_busy && exp_to && n == INH + 1 + TMO) begin
                check("timeout_due", 32'(done), 32'd1);
            end
            if (m_busy && done) begin
                m_busy = 1'b0;
            end else if (!m_busy && tx_valid) begin
                m_busy = 1'b1;
                n = 1;
                accepts++;
            end else if (m_busy) begin
                n++;
            end
        end
    end

    // PS/2 device: start when clock is released with data low, 11 clocks, sample on rising edges
    int dev_falls = 0;
    logic [10:0] fr_a, fr_b;
    bit ok_a, ok_b;

    task automatic device(input bit ack, output logic [10:0] fr, output bit ok);
        int t;
        t = 0;
        fr = 11'd0;
        ok = 1'b0;
        while (!(kb_clk_line && !kb_data_line) && t < 10000) begin
            @(negedge clk);
            t++;
        end
        if (t < 10000) begin
            ok = 1'b1;
            fr[0] = kb_data_line;
            #(HALF);
            for (int k = 1; k <= 11; k++) begin
                if (dev_abort) break;
                dev_clk_low = 1'b1;
                dev_falls++;
                #(HALF);
                dev_clk_low = 1'b0;
                if (k <= 10) fr[k] = kb_data_line;
                if (k == 10 && ack) begin
                    #(HALF / 2);
                    dev_data_low = 1'b1;
                    #(HALF / 2);
                end else begin
                    #(HALF);
                end
            end
            dev_clk_low = 1'b0;
            dev_data_low = 1'b0;
        end
    endtask

    task automatic wait_accept(input int target);
        int t;
        t = 0;
        while (accepts < target && t < 20000) begin
            @(negedge clk);
            #1;
            t++;
        end
        check("accept_wait", 32'(accepts), 32'(target));
    endtask

    task automatic wait_dones(input int target);
        int t;
        t = 0;
        while (dones < target && t < 10000) begin
            @(negedge clk);
            #1;
            t++;
        end
        check("done_count", 32'(dones), 32'(target));
    endtask

    task automatic send(input logic [7:0] b);
        int target;
        target = accepts + 1;
        tx_data = b;
        tx_valid = 1'b1;
        wait_accept(target);
        @(posedge clk);
        #1;
        tx_valid = 1'b0;
    endtask

    initial begin
        #3ms;
        $display("FAIL watchdog: simulation did not finish, got running expected finished");
        $fatal(1, "watchdog");
    end

    initial begin
        int d0;
        int a0;
        tx_data = 8'h00;
        tx_valid = 1'b0;
        dev_clk_low = 1'b0;
        dev_data_low = 1'b0;
        dev_abort = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        check("pd_in_reset", 32'({kb_clk_pd, kb_data_pd, done, busy}), 32'd0);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("reset_state", 32'({tx_ready, busy, done, err_nack, err_timeout, kb_clk_pd, kb_data_pd}), 32'b1000000);

        // 0xED with ack
        exp_nack = 1'b0; exp_to = 1'b0;
        clk_hi_cnt = 0; both_hi_cnt = 0;
        d0 = dones;
        fork
            device(1'b1, fr_a, ok_a);
            send(8'hED);
        join
        wait_dones(d0 + 1);
        check("ed_dev_started", 32'(ok_a), 32'd1);
        check("ed_frame", 32'(fr_a), 32'h7DA);
        check("ed_clk_pd_cycles", 32'(clk_hi_cnt), 32'd21);
        check("ed_req_cycles", 32'(both_hi_cnt), 32'd1);

        // 0x00 then 0x01, tx_valid held high
        d0 = dones;
        a0 = accepts;
        dev_falls = 0;
        fork
            begin
                device(1'b1, fr_a, ok_a);
                device(1'b1, fr_b, ok_b);
            end
            begin
                tx_data = 8'h00;
                tx_valid = 1'b1;
                wait_accept(a0 + 1);
                @(posedge clk);
                #1;
                tx_data = 8'h01;
                wait_accept(a0 + 2);
                @(posedge clk);
                #1;
                tx_valid = 1'b0;
            end
        join
        wait_dones(d0 + 2);
        check("b2b_frame0", 32'(fr_a), 32'(frame_of(8'h00)));
        check("b2b_frame1", 32'(fr_b), 32'(frame_of(8'h01)));
        check("b2b_par0", 32'(fr_a[9]), 32'd1);
        check("b2b_par1", 32'(fr_b[9]), 32'd0);

        // NACK
        exp_nack = 1'b1; exp_to = 1'b0;
        d0 = dones;
        fork
            device(1'b0, fr_a, ok_a);
            send(8'h5A);
        join
        wait_dones(d0 + 1);
        check("nack_frame", 32'(fr_a), 32'(frame_of(8'h5A)));
        repeat (3) @(negedge clk);
        check("nack_lines_released", 32'({kb_clk_line, kb_data_line}), 32'b11);

        // Timeout: no device clocks
        exp_nack = 1'b0; exp_to = 1'b1;
        d0 = dones;
        send(8'h55);
        wait_dones(d0 + 1);
        check("timeout_done_n", 32'(done_n), 32'd5021);
        exp_to = 1'b0;

        // Reset at bit_idx 4 while sending 0xF0
        d0 = dones;
        dev_falls = 0;
        fork
            device(1'b1, fr_a, ok_a);
            send(8'hF0);
            begin
                int t;
                t = 0;
                while (dev_falls < 4 && t < 10000) begin
                    @(negedge clk);
                    t++;
                end
                #(HALF / 2 + 3);
                check("pd_before_rst", 32'({kb_clk_pd, kb_data_pd}), 32'b01);
                rst = 1'b0;
                #1;
                check("pd_async_rst", 32'({kb_clk_pd, kb_data_pd}), 32'b00);
                dev_abort = 1'b1;
            end
        join
        repeat (5) @(posedge clk);
        #1;
        rst = 1'b1;
        dev_abort = 1'b0;
        repeat (50) @(posedge clk);
        #1;
        check("no_done_after_rst", 32'(dones), 32'(d0));
        fork
            device(1'b1, fr_a, ok_a);
            send(8'hFF);
        join
        wait_dones(d0 + 1);
        check("ff_frame", 32'(fr_a), 32'(frame_of(8'hFF)));
        check("ff_par", 32'(fr_a[9]), 32'd1);

        // Request during SEND is ignored
        d0 = dones;
        a0 = accepts;
        dev_falls = 0;
        fork
            device(1'b1, fr_a, ok_a);
            send(8'hF4);
            begin
                int t;
                t = 0;
                while (dev_falls < 3 && t < 10000) begin
                    @(negedge clk);
                    t++;
                end
                @(posedge clk);
                #1;
                tx_data = 8'hAA;
                tx_valid = 1'b1;
                @(posedge clk);
                #1;
                tx_valid = 1'b0;
            end
        join
        wait_dones(d0 + 1);
        repeat (200) @(posedge clk);
        #1;
        check("ign_frame", 32'(fr_a), 32'(frame_of(8'hF4)));
        check("ign_single_done", 32'(dones), 32'(d0 + 1));
        check("ign_idle", 32'({busy, tx_ready}), 32'b01);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/ps2_host_tx.md
Name: ps2_host_tx

Overview:
PS/2 host-to-device transmitter. It sends command bytes to the keyboard, for example 0xED followed by an LED mask, or 0xFF reset. It shares the kb_clk/kb_data lines with the keyboard receiver path in keyboard_top. It drives the open-collector lines through active-high pull-low enables that the top level turns into tristate buffers, and it reports busy so the receiver can ignore device clocks during a transmission.

Parameters:
INHIBIT_CYCLES, 12000, clk cycles to hold kb_clk low before the request (120 us at 100 MHz).
TIMEOUT_CYCLES, 2000000, maximum clk cycles from the REQ state to the end of WAIT_IDLE (20 ms at 100 MHz).

Ports:
clk  in  1  system clock, 100 MHz.
rst  in  1  asynchronous, active-low reset.
tx_data  in  8  command byte; sampled when the handshake completes.
tx_valid  in  1  request to send tx_data.
tx_ready  out  1  high only in IDLE; a transfer is accepted when tx_valid and tx_ready are both high.
kb_clk_in  in  1  raw PS/2 clock line (asynchronous).
kb_data_in  in  1  raw PS/2 data line (asynchronous).
kb_clk_pd  out  1  1 = pull kb_clk low, 0 = release.
kb_data_pd  out  1  1 = pull kb_data low, 0 = release.
busy  out  1  high in every state except IDLE; keyboard_top gates its receiver with it.
done  out  1  one-cycle pulse when a transfer ends, on success or error.
err_nack  out  1  valid with done; the device did not acknowledge.
err_timeout  out  1  valid with done; TIMEOUT_CYCLES was exceeded.

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE. tx_ready=1 after reset is released. kb_clk_pd=0, kb_data_pd=0, busy=0, done=0, both error flags 0, counters 0. Both lines are released immediately, including mid-transfer.
- Line synchronisation: kb_clk_in and kb_data_in each pass through 2 flops. A falling edge (fe) is synced-clock previous=1 and current=0, and lasts one cycle.
- Parity: odd. par = ~^tx_data, computed from the latched byte.
- IDLE: on tx_valid&tx_ready, latch the byte and compute par, then go to INHIBIT. tx_valid in any other state is ignored, with no queuing.
- INHIBIT: kb_clk_pd=1, kb_data_pd=0 for exactly INHIBIT_CYCLES cycles, then go to REQ.
- REQ: one cycle with kb_clk_pd=1 and kb_data_pd=1 (start bit). The timeout counter starts here. Then go to SEND with bit_idx=0.
- SEND: kb_clk_pd=0 (clock released) and the start bit stays driven. On each fe:
  - bit_idx 0..7: kb_data_pd = ~byte[bit_idx], LSB first.
  - bit_idx 8: kb_data_pd = ~par.
  - bit_idx 9: kb_data_pd = 0 (stop bit, line released); go to ACK.
  - bit_idx increments on each fe.
  - The data line changes the cycle after fe is detected.
- ACK: on the next fe, sample synced data. 0 means ack; 1 sets err_nack. Go to WAIT_IDLE in both cases.
- WAIT_IDLE: wait until synced clk=1 and data=1 in the same cycle. Then pulse done (with err_nack if it was set) and return to IDLE.
- Timeout: if the counter reaches TIMEOUT_CYCLES in REQ, SEND, ACK or WAIT_IDLE:
  - release both lines in the same cycle;
  - pulse done with err_timeout=1 and err_nack=0;
  - go to IDLE.
  Timeout takes priority over an fe in the same cycle.
- Error flags are valid only while done is high; they are 0 at all other times.
- tx_ready returns to 1 in the cycle after done.
- Reset mid-operation: the byte is discarded and no done pulse is produced.

Test Plan:
- Bench setup for all scenarios: INHIBIT_CYCLES=20, TIMEOUT_CYCLES=5000. A device model clocks at 1 µs half-period after sensing kb_clk released with data low, samples data on rising edges, and drives the ack low on clock 11.
- Send 0xED: kb_clk_pd is high for exactly 20 cycles, then 1 REQ cycle. Device sees start 0, bits 1,0,1,1,0,1,1,1, parity 1, stop 1. done fires with both error flags 0, tx_ready returns to 1, busy is high throughout.
- Send 0x00 then 0x01 back-to-back, with tx_valid held high: the device sees parity 1 for 0x00 and 0 for 0x01. The second byte is accepted only after the first done. Two done pulses occur, with no errors.
- NACK: the device model leaves data high on clock 11. Response is done with err_nack=1 and err_timeout=0, and both lines are released.
- Timeout: the device never clocks. At REQ+5000 cycles, kb_clk_pd=0, kb_data_pd=0, done=1 and err_timeout=1, and the block is in IDLE on the next cycle.
- Reset mid-transfer: assert rst=0 at bit_idx=4. Both pd outputs go to 0 asynchronously, no done pulse appears, and after release a fresh send of 0xFF completes normally with parity 1.
- Ignored request: pulse tx_valid with 0xAA during SEND of 0xF4. The device receives only 0xF4, and only one done pulse occurs.
